ula_operand_seq: RTL and testbench
==================================

Name: ula_operand_seq

Overview:
- Operand-entry sequencer that sits directly upstream of the 4-bit ULA. It also latches the ULA's result.
- It collects A, B and the opcode from board switches, one debounced ENTER press per item.
- It drives a/b/op to the ULA and holds them stable. It then registers the ULA's result and range code for the display stage.
- It blocks division by zero before the ULA ever sees it.

Parameters:
- DATA_W, 4, operand/result width; must match the ULA.
- DEBOUNCE_CYC, 4, number of consecutive synchronized-high cycles on enter that count as one press (>=1).
- OP_DIV, 3, opcode value of the divide operation, used for the zero-divisor check.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- sw  in  DATA_W  operand switches (asynchronous, quasi-static).
- op_sw  in  2  opcode switches: 0 sum, 1 sub, 2 mult, 3 div.
- enter  in  1  raw pushbutton, active-high, asynchronous.
- clear  in  1  synchronous abort, active-high; already synchronous to clk.
- res_in  in  DATA_W  ULA result (combinational from a/b/op).
- flag_in  in  4  ULA range/status code.
- a  out  DATA_W  operand A to the ULA.
- b  out  DATA_W  operand B to the ULA.
- op  out  2  opcode to the ULA.
- alu_valid  out  1  high while a/b/op are a complete, legal operation.
- res  out  DATA_W  registered ULA result.
- res_flag  out  4  registered ULA status code.
- err  out  1  division-by-zero indication.
- state  out  3  FSM state code for LEDs.

Behaviour:
- Reset: rst_n=0 at a clock edge forces the following, regardless of state or in-flight press:
  - a=b=res=0, op=0, res_flag=0, err=0, alu_valid=0, state=GET_A.
  - Synchronizer flops and debounce counter cleared.
- clear=1: same effect as reset, but rst_n has priority.
- Enter conditioning:
  - 2-flop synchronizer gives enter_s.
  - Counter cnt increments while enter_s=1 and saturates at DEBOUNCE_CYC.
  - cnt clears to 0 in any cycle enter_s=0.
  - press is a 1-cycle pulse in the cycle cnt goes DEBOUNCE_CYC-1 -> DEBOUNCE_CYC.
  - One press per hold, however long the button stays down. A glitch shorter than DEBOUNCE_CYC synchronized cycles gives no press.
  - Latency: enter high at edge k -> press high in the cycle after edge k+1+DEBOUNCE_CYC.
- FSM encodings: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4, ERR=5. Encodings 6 and 7 go to GET_A.
- GET_A: on press, a<=sw; go to GET_B.
- GET_B: on press, b<=sw; go to GET_OP.
- GET_OP: on press, op<=op_sw.
  - If op_sw==OP_DIV and b==0: err<=1, res<=0, res_flag<=0; go to ERR.
  - Otherwise go to EXEC.
- EXEC (exactly 1 cycle, ignores press):
  - res<=res_in, res_flag<=flag_in.
  - Go to SHOW.
- SHOW: holds res/res_flag. On press, go to GET_A; a, b, op keep their values until overwritten.
- ERR: holds err=1. On press, err<=0; go to GET_A.
- alu_valid = 1 in EXEC and SHOW, else 0; it is a decode of state (combinational).
- a, b, op change only on their load press. They are stable from the EXEC cycle through SHOW, so the ULA output is settled before capture.
- A press arriving in the same cycle as clear or reset is discarded.
- Switch values are sampled only on press, so switch changes between presses have no effect.

Test Plan:
- Reset then sum (DEBOUNCE_CYC=4):
  - Stimulus: rst_n low 2 cycles; enter A=5, B=7, op=0; ULA model gives res_in=12, flag_in=1.
  - Required: state steps 0,1,2,3,4; alu_valid rises in EXEC; res=12, res_flag=1 in SHOW; a=5, b=7 stable.
- Debounce:
  - Stimulus: enter pulse 2 cycles wide.
  - Required: no state change.
  - Stimulus: enter held 50 cycles.
  - Required: exactly one state advance, with press exactly 1+DEBOUNCE_CYC+1 cycles after enter rises.
- Divide by zero:
  - Stimulus: A=9, B=0, op=3.
  - Required: state=ERR, err=1, res=0, alu_valid=0 throughout.
  - Stimulus: next press.
  - Required: err=0, state=GET_A.
- Legal divide:
  - Stimulus: A=8, B=2, op=3, res_in=4.
  - Required: EXEC then SHOW with res=4, no err.
- Abort:
  - Stimulus: clear pulse while in GET_OP with a=3, b=4.
  - Required: next cycle a=b=0, state=GET_A.
  - Stimulus: rst_n low in SHOW during a held enter.
  - Required: all outputs reset; no spurious press after release unless a new press of at least DEBOUNCE_CYC cycles follows.
- Illegal state:
  - Stimulus: force state=6.
  - Required: GET_A on the next cycle.

Source files
------------

// File: rtl/ula_operand_seq_if.sv
// Bundle of all non-clock signals between the operand sequencer, the board
// switches/buttons and the 4-bit ULA. The sequencer uses the slave view;
// whatever drives the switches and models the ULA uses the master view.
interface ula_operand_seq_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] sw;
    logic [1:0]        op_sw;
    logic              enter;
    logic              clear;
    logic [DATA_W-1:0] res_in;
    logic [3:0]        flag_in;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        op;
    logic              alu_valid;
    logic [DATA_W-1:0] res;
    logic [3:0]        res_flag;
    logic              err;
    logic [2:0]        state;

    modport master (
        output sw, op_sw, enter, clear, res_in, flag_in,
        input  a, b, op, alu_valid, res, res_flag, err, state
    );

    modport slave (
        input  sw, op_sw, enter, clear, res_in, flag_in,
        output a, b, op, alu_valid, res, res_flag, err, state
    );
endinterface

// File: rtl/ula_operand_seq.sv
// Operand-entry sequencer for the 4-bit ULA. A, B and the opcode are taken
// from the switches one debounced ENTER press at a time. The ULA result is
// then captured for the display stage. A divide with a zero divisor is
// trapped in an error state, so the ULA never sees it as a valid operation.
module ula_operand_seq #(
    parameter int DATA_W       = 4,
    parameter int DEBOUNCE_CYC = 4,
    parameter int OP_DIV       = 3
) (
    input logic             clk,
    input logic             rst_n,
    ula_operand_seq_if.slave bus
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]   CNT_ARM  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [1:0]         DIV_CODE = 2'(OP_DIV);

    logic              abort;
    logic              sync1;
    logic              enter_s;
    logic [CNT_W-1:0]  cnt;
    logic              press;

    // Held as plain bits so that the illegal codes 6 and 7 stay representable.
    logic [2:0]        state_q;
    state_t            state_d;

    logic              load_a;
    logic              load_b;
    logic              load_op;
    logic              set_err;
    logic              clr_err;
    logic              capture;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] res_q;
    logic [3:0]        flag_q;
    logic              err_q;

    // Reset and clear have the same effect. Both also flush any press in flight.
    assign abort = !rst_n || bus.clear;

    // Two-flop synchronizer for the raw pushbutton.
    always_ff @(posedge clk) begin
        if (abort) begin
            sync1   <= 1'b0;
            enter_s <= 1'b0;
        end else begin
            sync1   <= bus.enter;
            enter_s <= sync1;
        end
    end

    // Saturating debounce counter. It emits a one-cycle press on the step into saturation.
    always_ff @(posedge clk) begin
        if (abort) begin
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= enter_s && (cnt == CNT_ARM);
            if (!enter_s) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next-state decode and the register-load strobes for each step of entry.
    always_comb begin
        state_d = GET_A;
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_op = 1'b0;
        set_err = 1'b0;
        clr_err = 1'b0;
        capture = 1'b0;
        case (state_q)
            GET_A: begin
                if (press) begin
                    load_a  = 1'b1;
                    state_d = GET_B;
                end else begin
                    state_d = GET_A;
                end
            end
            GET_B: begin
                if (press) begin
                    load_b  = 1'b1;
                    state_d = GET_OP;
                end else begin
                    state_d = GET_B;
                end
            end
            GET_OP: begin
                if (press) begin
                    load_op = 1'b1;
                    if (bus.op_sw == DIV_CODE && b_q == '0) begin
                        set_err = 1'b1;
                        state_d = ERR;
                    end else begin
                        state_d = EXEC;
                    end
                end else begin
                    state_d = GET_OP;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = SHOW;
            end
            SHOW: begin
                state_d = press ? GET_A : SHOW;
            end
            ERR: begin
                if (press) begin
                    clr_err = 1'b1;
                    state_d = GET_A;
                end else begin
                    state_d = ERR;
                end
            end
            default: begin
                state_d = GET_A;
            end
        endcase
    end

    // State, operand, result and error registers. They are loaded only by the strobes above.
    always_ff @(posedge clk) begin
        if (abort) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flag_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_a) begin
                a_q <= bus.sw;
            end
            if (load_b) begin
                b_q <= bus.sw;
            end
            if (load_op) begin
                op_q <= bus.op_sw;
            end
            if (set_err) begin
                err_q  <= 1'b1;
                res_q  <= '0;
                flag_q <= '0;
            end
            if (capture) begin
                res_q  <= bus.res_in;
                flag_q <= bus.flag_in;
            end
            if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.op        = op_q;
    assign bus.res       = res_q;
    assign bus.res_flag  = flag_q;
    assign bus.err       = err_q;
    assign bus.state     = state_q;
    assign bus.alu_valid = (state_q == EXEC) || (state_q == SHOW);

endmodule

// File: tb/tb_ula_operand_seq.sv
// Directed bench for the ULA operand sequencer. It uses hand-computed
// expected values with DEBOUNCE_CYC=4. The ULA result is driven as a
// constant per scenario.
module tb_ula_operand_seq;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;

    ula_operand_seq_if #(.DATA_W(4)) bus ();

    ula_operand_seq #(
        .DATA_W(4),
        .DEBOUNCE_CYC(4),
        .OP_DIV(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full ENTER press: idle long enough for the synchronizer to drain,
    // then hold until the state moves, and release right away.
    task automatic applyStimulus(input logic [3:0] sw_val, input logic [1:0] op_val);
        logic [2:0] start;
        int         n;
        bus.enter = 1'b0;
        repeat (3) tick();
        bus.sw    = sw_val;
        bus.op_sw = op_val;
        start     = bus.state;
        bus.enter = 1'b1;
        n         = 0;
        do begin
            tick();
            n++;
        end while (bus.state == start && n < 20);
        bus.enter = 1'b0;
        if (n >= 20) begin
            checkOutput("press_timeout", 32'(n), 32'd7);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, 32'(bus.state), 32'd0);
        checkOutput({tag, "_a"}, 32'(bus.a), 32'd0);
        checkOutput({tag, "_b"}, 32'(bus.b), 32'd0);
        checkOutput({tag, "_op"}, 32'(bus.op), 32'd0);
        checkOutput({tag, "_res"}, 32'(bus.res), 32'd0);
        checkOutput({tag, "_res_flag"}, 32'(bus.res_flag), 32'd0);
        checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
        checkOutput({tag, "_alu_valid"}, 32'(bus.alu_valid), 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        int n;
        checkCount  = 0;
        passCount   = 0;
        rst_n       = 1'b0;
        bus.sw      = '0;
        bus.op_sw   = '0;
        bus.enter   = 1'b0;
        bus.clear   = 1'b0;
        bus.res_in  = '0;
        bus.flag_in = '0;

        repeat (2) tick();
        checkResetValues("reset");
        rst_n = 1'b1;
        tick();

        // A two-cycle glitch must not count as a press.
        bus.sw    = 4'd5;
        bus.enter = 1'b1;
        repeat (2) tick();
        bus.enter = 1'b0;
        repeat (10) tick();
        checkOutput("glitch_state", 32'(bus.state), 32'd0);

        // Long hold: exactly one advance, with a latency of 1+DEBOUNCE_CYC+1 after the first edge.
        bus.enter = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.state == 3'd0 && n < 40);
        checkOutput("press_latency", 32'(n), 32'd7);
        repeat (50 - n) tick();
        checkOutput("hold_state", 32'(bus.state), 32'd1);
        checkOutput("hold_a", 32'(bus.a), 32'd5);
        bus.enter = 1'b0;

        // Sum: 5 + 7 -> 12, flag 1.
        bus.res_in  = 4'd12;
        bus.flag_in = 4'd1;
        applyStimulus(4'd7, 2'd0);
        checkOutput("sum_state_b", 32'(bus.state), 32'd2);
        checkOutput("sum_b", 32'(bus.b), 32'd7);
        applyStimulus(4'd0, 2'd0);
        checkOutput("sum_exec_state", 32'(bus.state), 32'd3);
        checkOutput("sum_exec_valid", 32'(bus.alu_valid), 32'd1);
        tick();
        checkOutput("sum_show_state", 32'(bus.state), 32'd4);
        checkOutput("sum_res", 32'(bus.res), 32'd12);
        checkOutput("sum_res_flag", 32'(bus.res_flag), 32'd1);
        checkOutput("sum_a", 32'(bus.a), 32'd5);
        checkOutput("sum_b_stable", 32'(bus.b), 32'd7);
        checkOutput("sum_show_valid", 32'(bus.alu_valid), 32'd1);
        applyStimulus(4'd0, 2'd0);
        checkOutput("show_exit_state", 32'(bus.state), 32'd0);
        checkOutput("show_exit_a_kept", 32'(bus.a), 32'd5);

        // Divide by zero: 9 / 0.
        applyStimulus(4'd9, 2'd0);
        applyStimulus(4'd0, 2'd0);
        applyStimulus(4'd0, 2'd3);
        checkOutput("dz_state", 32'(bus.state), 32'd5);
        checkOutput("dz_err", 32'(bus.err), 32'd1);
        checkOutput("dz_res", 32'(bus.res), 32'd0);
        checkOutput("dz_res_flag", 32'(bus.res_flag), 32'd0);
        checkOutput("dz_valid", 32'(bus.alu_valid), 32'd0);
        checkOutput("dz_op", 32'(bus.op), 32'd3);
        repeat (5) tick();
        checkOutput("dz_err_held", 32'(bus.err), 32'd1);
        checkOutput("dz_valid_held", 32'(bus.alu_valid), 32'd0);
        applyStimulus(4'd0, 2'd0);
        checkOutput("dz_exit_state", 32'(bus.state), 32'd0);
        checkOutput("dz_exit_err", 32'(bus.err), 32'd0);

        // Legal divide: 8 / 2 -> 4.
        bus.res_in  = 4'd4;
        bus.flag_in = 4'd0;
        applyStimulus(4'd8, 2'd0);
        applyStimulus(4'd2, 2'd0);
        applyStimulus(4'd0, 2'd3);
        checkOutput("div_exec_state", 32'(bus.state), 32'd3);
        checkOutput("div_exec_err", 32'(bus.err), 32'd0);
        tick();
        checkOutput("div_show_state", 32'(bus.state), 32'd4);
        checkOutput("div_res", 32'(bus.res), 32'd4);
        checkOutput("div_err", 32'(bus.err), 32'd0);
        applyStimulus(4'd0, 2'd0);

        // Clear while in GET_OP with a=3, b=4.
        applyStimulus(4'd3, 2'd0);
        applyStimulus(4'd4, 2'd0);
        checkOutput("clr_pre_state", 32'(bus.state), 32'd2);
        checkOutput("clr_pre_a", 32'(bus.a), 32'd3);
        checkOutput("clr_pre_b", 32'(bus.b), 32'd4);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checkOutput("clr_a", 32'(bus.a), 32'd0);
        checkOutput("clr_b", 32'(bus.b), 32'd0);
        checkOutput("clr_state", 32'(bus.state), 32'd0);

        // Reset in SHOW while enter is held; the button is released during reset.
        bus.res_in = 4'd2;
        applyStimulus(4'd1, 2'd0);
        applyStimulus(4'd1, 2'd0);
        applyStimulus(4'd0, 2'd0);
        tick();
        checkOutput("rst_pre_state", 32'(bus.state), 32'd4);
        bus.enter = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        bus.enter = 1'b0;
        tick();
        rst_n = 1'b1;
        checkResetValues("rst_show");
        repeat (20) tick();
        checkOutput("rst_no_spurious", 32'(bus.state), 32'd0);
        applyStimulus(4'd6, 2'd0);
        checkOutput("rst_new_press_state", 32'(bus.state), 32'd1);
        checkOutput("rst_new_press_a", 32'(bus.a), 32'd6);

        // An illegal state code recovers to GET_A on the next edge.
        force dut.state_q = 3'd6;
        #2;
        release dut.state_q;
        checkOutput("illegal_forced", 32'(bus.state), 32'd6);
        tick();
        checkOutput("illegal_recover", 32'(bus.state), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
